rc5_key_expand: RTL and testbench
=================================

# rc5_key_expand

RC5-32/12/16 key-schedule engine directly upstream of the decryption stage. It accepts a 128-bit secret key, runs the standard RC5 key expansion (init plus 78 mixing iterations), and holds the 26-word expanded table S[0..25]. The decryption stage reads round keys through an asynchronous read port instead of a fixed ROM. One expansion per key load; the table is stable and readable until the next key is accepted.

## Interface
Parameters:
- W, 32: word width, fixed for RC5-32.
- T, 26: table words, 2*(R+1) with R=12.
- C, 4: key words, 128-bit key / W.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset: asynchronous, active-low.
- key  in  128  secret key; byte K[n] = key[8n+7:8n], L[j] = key[32j+31:32j] (little-endian words).
- key_valid  in  1  request to load `key`; sampled on the rising edge of `clk`.
- busy  out  1  high while expansion runs (INIT or MIX).
- keys_ready  out  1  high when S[0..25] is complete and stable.
- rk_addr  in  5  round-key index.
- rk_data  out  32  S[rk_addr] (combinational); 0 if rk_addr > 25 or keys_ready = 0.

## Operation
- States: IDLE, INIT, MIX, DONE. Reset state is IDLE.
- IDLE/DONE, key_valid=1:
  - load L[0..3] from key; clear A, B, i, j, cnt; load init accumulator with P32 = 0xB7E15163.
  - go to INIT; keys_ready drops the same edge.
- INIT, one word per cycle for cnt = 0..25:
  - S[cnt] <= acc; acc <= acc + Q32, with Q32 = 0x9E3779B9 (mod 2^32).
  - at cnt = 25: cnt <= 0, go to MIX.
- MIX, one iteration per cycle for cnt = 0..77:
  - a_n = rotl(S[i] + A + B, 3)
  - b_n = rotl(L[j] + a_n + B, (a_n + B)[4:0])
  - S[i] <= a_n; L[j] <= b_n; A <= a_n; B <= b_n.
  - i wraps 25→0; j wraps 3→0.
  - all additions are modulo 2^32; rotate amount is the low 5 bits only; amount 0 is identity.
  - at cnt = 77: go to DONE.
- DONE: keys_ready=1, table frozen, L/A/B retain final values.
- key_valid in INIT/MIX: ignored, no queuing.
- key_valid in DONE restarts expansion; the old table is lost as it is overwritten.
- key is sampled only on the accepting edge; later changes have no effect.
- Reset at any time (mid-INIT/MIX included):
  - state IDLE; busy=0, keys_ready=0, rk_data=0; A, B, i, j, cnt cleared.
  - S/L contents are don't-care; rk_data is masked to 0 regardless.

## Timing
- Acceptance edge E0. INIT writes on E1..E26. MIX runs on E27..E104.
- busy=1 from after E0 until E104; keys_ready=1 after E104, i.e. 104 cycles of latency.
- rk_data is combinational from rk_addr and the S array; no read latency, valid any cycle keys_ready=1.
- Critical path: two 32-bit three-operand adds plus one variable rotate per MIX cycle; single-cycle by requirement.

## Structure
- Package rc5_pkg holds:
  - constants P32, Q32, W=32, R=12, T=26, C=4;
  - the state enum {IDLE, INIT, MIX, DONE};
  - the key-word index width.
- The decryption stage imports the same package for T/R.
- One sub-module, rc5_rotl: 32-bit data, 5-bit amount, combinational left rotate. Instantiated twice (fixed-3 and variable).
- S is a 26x32 register array: single write port, one async read port, plus one internal read of S[i].

## Test plan
- Reset, then idle 5 cycles: busy=0, keys_ready=0, rk_data=0 for rk_addr 0..31.
- Load key=0, freeze just before E27 (bench peek): S[0]=0xB7E15163, S[1]=0x5618CB1C, S[25]=P32+25*Q32 mod 2^32.
- key=0 full run: keys_ready rises exactly 104 cycles after acceptance; S[0..25] equals the software RC5 reference model. Feeding that table to decryption, ciphertext 0x21A5DBEE154B8F6D → plaintext 0x0000000000000000.
- key_valid pulses at cycle 50 with a different key: ignored; result still matches the first key.
- Reset asserted at cycle 60 of MIX, then key=0x0F0E..0100 loaded: fresh 104-cycle run whose table matches the model for that key.
- rk_addr=26..31 in DONE → rk_data=0. Back-to-back key loads from DONE each produce correct tables, with keys_ready low throughout each run.

Source files
------------

// File: rtl/rc5_pkg.sv
// RC5-32/12/16 shared constants and key-schedule state encoding.
package rc5_pkg;
    localparam int W  = 32;
    localparam int R  = 12;
    localparam int T  = 2 * (R + 1);
    localparam int C  = 4;
    localparam int IW = $clog2(T);
    localparam int JW = $clog2(C);
    localparam int NW = 7;

    localparam logic [31:0] P32 = 32'hB7E1_5163;
    localparam logic [31:0] Q32 = 32'h9E37_79B9;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        MIX,
        DONE
    } state_t;
endpackage

// File: rtl/rc5_rotl.sv
// 32-bit combinational left rotate by a 5-bit amount.
module rc5_rotl (
    input  logic [31:0] data,
    input  logic [4:0]  amt,
    output logic [31:0] y
);
    logic [63:0] dd;

    assign dd = {data, data} << amt;
    assign y  = dd[63:32];
endmodule

// File: rtl/rc5_key_expand.sv
// RC5-32/12/16 key expansion: S table build plus 78 mixing steps,
// exposed to the decryption stage through an async read port.
module rc5_key_expand #(
    parameter int W = 32,
    parameter int T = 26,
    parameter int C = 4
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [C*W-1:0] key,
    input  logic           key_valid,
    output logic           busy,
    output logic           keys_ready,
    input  logic [4:0]     rk_addr,
    output logic [W-1:0]   rk_data
);
    import rc5_pkg::*;

    state_t        state;
    logic [W-1:0]  s [T];
    logic [W-1:0]  l [C];
    logic [W-1:0]  a, b, acc;
    logic [IW-1:0] i;
    logic [JW-1:0] j;
    logic [NW-1:0] cnt;

    logic [W-1:0]  s_i, sum1, a_n, ab, sum2, b_n;
    logic          accept;

    assign accept = (state == IDLE || state == DONE) && key_valid;

    assign s_i  = s[i];
    assign sum1 = s_i + a + b;
    assign ab   = a_n + b;
    assign sum2 = l[j] + ab;

    rc5_rotl u_rot3 (
        .data (sum1),
        .amt  (5'd3),
        .y    (a_n)
    );

    rc5_rotl u_rotv (
        .data (sum2),
        .amt  (ab[4:0]),
        .y    (b_n)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= IDLE;
            busy       <= 1'b0;
            keys_ready <= 1'b0;
            a          <= '0;
            b          <= '0;
            acc        <= '0;
            i          <= '0;
            j          <= '0;
            cnt        <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (key_valid) begin
                        state      <= INIT;
                        busy       <= 1'b1;
                        keys_ready <= 1'b0;
                        a          <= '0;
                        b          <= '0;
                        i          <= '0;
                        j          <= '0;
                        cnt        <= '0;
                        acc        <= P32;
                    end
                end
                INIT: begin
                    acc <= acc + Q32;
                    if (cnt == NW'(T - 1)) begin
                        cnt   <= '0;
                        state <= MIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                MIX: begin
                    a <= a_n;
                    b <= b_n;
                    i <= (i == IW'(T - 1)) ? '0 : i + 1'b1;
                    j <= (j == JW'(C - 1)) ? '0 : j + 1'b1;
                    if (cnt == NW'(3 * T - 1)) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        keys_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Table and key words carry no reset; reads are masked by keys_ready.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int n = 0; n < C; n++) begin
                l[n] <= key[n*W +: W];
            end
        end else if (state == INIT) begin
            s[cnt[IW-1:0]] <= acc;
        end else if (state == MIX) begin
            s[i] <= a_n;
            l[j] <= b_n;
        end
    end

    always_comb begin
        rk_data = '0;
        if (keys_ready && rk_addr < 5'(T)) begin
            rk_data = s[rk_addr];
        end
    end
endmodule

// File: tb/tb_rc5_key_expand.sv
// Scoreboard bench for rc5_key_expand against a software RC5 model.
module tb_rc5_key_expand;
    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic [127:0] key = '0;
    logic         key_valid = 1'b0;
    logic         busy;
    logic         keys_ready;
    logic [4:0]   rk_addr = '0;
    logic [31:0]  rk_data;

    rc5_key_expand u_dut (
        .clk        (clk),
        .clr        (clr),
        .key        (key),
        .key_valid  (key_valid),
        .busy       (busy),
        .keys_ready (keys_ready),
        .rk_addr    (rk_addr),
        .rk_data    (rk_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [127:0] k;
        int           t0;
        bit           kat;
    } exp_t;

    exp_t sbq[$];

    localparam logic [31:0] P = 32'hB7E15163;
    localparam logic [31:0] Q = 32'h9E3779B9;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x,
                                         input logic [4:0] r);
        if (r == 0) return x;
        return (x << r) | (x >> (32 - int'(r)));
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x,
                                         input logic [4:0] r);
        if (r == 0) return x;
        return (x >> r) | (x << (32 - int'(r)));
    endfunction

    function automatic logic [831:0] expand(input logic [127:0] k);
        logic [31:0]  s [26];
        logic [31:0]  l [4];
        logic [31:0]  a, b;
        logic [831:0] o;
        int           i, j;
        a = 0;
        b = 0;
        i = 0;
        j = 0;
        for (int n = 0; n < 4; n++) l[n] = k[n*32 +: 32];
        s[0] = P;
        for (int n = 1; n < 26; n++) s[n] = s[n-1] + Q;
        for (int n = 0; n < 78; n++) begin
            a = rotl(s[i] + a + b, 5'd3);
            b = rotl(l[j] + a + b, 5'(a + b));
            s[i] = a;
            l[j] = b;
            i = (i + 1) % 26;
            j = (j + 1) % 4;
        end
        for (int n = 0; n < 26; n++) o[n*32 +: 32] = s[n];
        return o;
    endfunction

    function automatic logic [63:0] dec(input logic [831:0] s,
                                        input logic [31:0] a0,
                                        input logic [31:0] b0);
        logic [31:0] a, b;
        a = a0;
        b = b0;
        for (int r = 12; r >= 1; r--) begin
            b = rotr(b - s[(2*r+1)*32 +: 32], a[4:0]) ^ a;
            a = rotr(a - s[(2*r)*32 +: 32], b[4:0]) ^ b;
        end
        b = b - s[32 +: 32];
        a = a - s[0 +: 32];
        return {a, b};
    endfunction

    // Monitor: masks while not ready, full table check on each ready rise.
    initial begin
        logic         prev;
        logic [831:0] m, got;
        logic [63:0]  pt;
        exp_t         e;
        prev = 1'b0;
        got  = '0;
        forever begin
            @(negedge clk);
            if (!clr) begin
                prev = 1'b0;
                continue;
            end
            rk_addr = 5'(cyc);
            #1;
            if (busy && keys_ready) begin
                n_chk++;
                n_fail++;
                $display("FAIL busy_and_ready: both high at cycle %0d", cyc);
            end
            if (!keys_ready) chk("rk_masked", rk_data, 32'h0);
            if (keys_ready && !prev) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_ready: no pending key at cycle %0d",
                             cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("latency", 32'(cyc - e.t0), 32'd104);
                    m = expand(e.k);
                    for (int n = 0; n < 32; n++) begin
                        rk_addr = 5'(n);
                        #1;
                        if (n < 26) begin
                            chk($sformatf("S[%0d]", n), rk_data, m[n*32 +: 32]);
                            got[n*32 +: 32] = rk_data;
                        end else begin
                            chk($sformatf("rk_oob[%0d]", n), rk_data, 32'h0);
                        end
                    end
                    if (e.kat) begin
                        pt = dec(got, 32'hEEDBA521, 32'h6D8F4B15);
                        chk("kat_pt_a", pt[63:32], 32'h0);
                        chk("kat_pt_b", pt[31:0], 32'h0);
                    end
                end
            end
            prev = keys_ready;
        end
    end

    task automatic load(input logic [127:0] k, input bit kat,
                        output int t0);
        @(negedge clk);
        key       = k;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        t0        = cyc;
        key       = ~k;
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_ready", 32'(keys_ready), 32'd0);
        sbq.push_back('{k: k, t0: t0, kat: kat});
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (keys_ready) seen = 1'b1;
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL ready_timeout: keys_ready=%0b after 200 cycles, want 1",
                     keys_ready);
        end
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_ready", 32'(keys_ready), 32'd0);
            chk("idle_rk", rk_data, 32'h0);
        end

        load(128'h0, 1'b1, t0);
        repeat (26) @(posedge clk);
        #1;
        chk("peek_S0", u_dut.s[0], 32'hB7E15163);
        chk("peek_S1", u_dut.s[1], 32'h5618CB1C);
        chk("peek_S25", u_dut.s[25], P + 32'd25 * Q);
        chk("peek_busy", 32'(busy), 32'd1);
        wait_done();

        load(128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0, t0);
        repeat (49) @(posedge clk);
        @(negedge clk);
        key       = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        chk("ignored_busy", 32'(busy), 32'd1);
        wait_done();

        load(128'hFFFFFFFF_00000000_A5A5A5A5_5A5A5A5A, 1'b0, t0);
        repeat (85) @(posedge clk);
        #2;
        clr = 1'b0;
        sbq.delete();
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(keys_ready), 32'd0);
        chk("rst_rk", rk_data, 32'h0);
        chk("rst_cnt", 32'(u_dut.cnt), 32'd0);
        @(negedge clk);
        clr = 1'b1;
        load(128'h0F0E0D0C0B0A09080706050403020100, 1'b0, t0);
        wait_done();

        load(128'h00000001_00000002_00000003_00000004, 1'b0, t0);
        wait_done();
        load(128'h80000000_7FFFFFFF_FFFFFFFF_00000001, 1'b0, t0);
        wait_done();

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
